// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide iteration counter.
// Holds the two-state sequencing enum and the default counter width.
// No logic; imported by multdiv_step_counter and its sub-module.
package multdiv_pkg;

  // Default counter width: enough for the 32/64 iterations of a word multdiv.
  localparam int unsigned MULTDIV_CNT_W = 6;

  // Sequencer state: idle (waiting for start) or running a sequence.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } cnt_state_e;

endpackage

// File: rtl/updown_counter_core.sv
// Plain loadable up/down register with asynchronous active-low clear.
// Latency: q reflects load/step one edge after the controlling inputs.
// Backpressure: none; en=0 simply holds q.
// Ports:
//   clk, clr_n     clock and asynchronous active-low clear
//   load, load_val synchronous load (takes priority over en)
//   en, dir        step enable and direction (0 = +1, 1 = -1), modulo 2^WIDTH
//   q              registered count
module updown_counter_core #(
  parameter int unsigned WIDTH = multdiv_pkg::MULTDIV_CNT_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en) begin
      cnt_d = dir ? (cnt_q - WIDTH'(1)) : (cnt_q + WIDTH'(1));
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/multdiv_step_counter.sv
// Iteration counter for the multdiv sequencer: start/busy/done around an up/down core.
// Latency: busy/q valid one edge after an accepted start; done one edge after final step.
// Backpressure: en=0 stalls the count; abort cancels a running sequence without done.
// Ports:
//   clk, clr_n          clock and asynchronous active-low clear
//   start, load_val,dir new-sequence request (accepted only when idle) with its parameters
//   en, abort           advance enable and synchronous cancel while running
//   q, busy             registered count and running flag
//   last                combinational final-iteration marker (busy & q == term)
//   done                one-cycle pulse after normal completion
module multdiv_step_counter
  import multdiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULTDIV_CNT_W  // must be >= 2
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             en,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             last,
  output logic             done
);

  cnt_state_e       state_q, state_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic             cnt_load;
  logic             cnt_en;
  logic [WIDTH-1:0] cnt_init;
  logic             at_term;

  assign at_term = (q == term_q);

  // Next-state and counter control. The count stops at term rather than
  // stepping past it, which is why q can never wrap in either direction.
  always_comb begin
    state_d  = state_q;
    term_d   = term_q;
    dir_d    = dir_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    cnt_init = load_val;

    unique case (state_q)
      IDLE: begin
        // start together with abort is dropped.
        if (start && !abort) begin
          state_d  = RUN;
          cnt_load = 1'b1;
          dir_d    = dir;
          // Up runs 0 -> load_val, down runs load_val -> 0.
          cnt_init = dir ? load_val : '0;
          term_d   = dir ? '0 : load_val;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (en) begin
          if (at_term) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      term_q  <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      term_q  <= term_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  updown_counter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk     (clk),
    .clr_n   (clr_n),
    .load    (cnt_load),
    .load_val(cnt_init),
    .en      (cnt_en),
    .dir     (dir_q),
    .q       (q)
  );

  assign busy = (state_q == RUN);
  assign last = busy & at_term;
  assign done = done_q;

endmodule

// File: tb/tb_multdiv_step_counter.sv
// Self-checking bench for multdiv_step_counter with a sequence-level reference model.
// Inputs change just after the falling edge; outputs are checked at the next falling edge.
// Directed scenarios first, then a randomized run against the same model.
module tb_multdiv_step_counter;

  localparam int W = 6;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         clr_n;
  logic         start;
  logic [W-1:0] load_val;
  logic         dir;
  logic         en;
  logic         abort;
  logic [W-1:0] q;
  logic         busy;
  logic         last;
  logic         done;

  int checks = 0;
  int errors = 0;

  // Reference model: a sequence is (load, dir) plus k = enabled steps taken.
  // Up shows q = k, down shows q = load - k; the step with k == load finishes.
  bit m_busy;
  bit m_done;
  int m_load;
  bit m_dir;
  int m_k;
  int m_q;

  multdiv_step_counter #(.WIDTH(W)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .load_val(load_val),
    .dir     (dir),
    .en      (en),
    .abort   (abort),
    .q       (q),
    .busy    (busy),
    .last    (last),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_load = 0; m_dir = 0; m_k = 0; m_q = 0;
  endtask

  task automatic model_edge(input bit st, input bit ab, input bit e, input bit d, input int ld);
    m_done = 0;
    if (!m_busy) begin
      if (st && !ab) begin
        m_busy = 1; m_load = ld; m_dir = d; m_k = 0;
        m_q = d ? ld : 0;
      end
    end else if (ab) begin
      m_busy = 0;
    end else if (e) begin
      if (m_k == m_load) begin
        m_busy = 0;
        m_done = 1;
      end else begin
        m_k++;
        m_q = m_dir ? (m_load - m_k) : m_k;
      end
    end
  endtask

  task automatic check_all();
    chk("q", 32'(q), 32'(m_q));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("last", 32'(last), 32'(m_busy && (m_k == m_load)));
  endtask

  // One clock: drive inputs (called right after a falling edge), clock, check.
  task automatic step(input bit st, input bit ab, input bit e, input bit d, input int ld);
    start = st; abort = ab; en = e; dir = d; load_val = W'(ld);
    @(posedge clk);
    model_edge(st, ab, e, d, ld);
    @(negedge clk);
    check_all();
  endtask

  // Start a sequence and advance until done; returns the enabled-cycle count.
  task automatic run_seq(input int ld, input bit d, input bit stall, output int n_en);
    bit e;
    n_en = 0;
    step(1, 0, 1, d, ld);
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_q", 32'(q), d ? 32'(ld) : 32'd0);
    for (int i = 0; i < 300; i++) begin
      e = stall ? (i % 2 == 0) : 1'b1;
      step(0, 0, e, d, $urandom_range(0, MAXV));
      if (e) n_en++;
      if (done) break;
    end
    chk("seq_done_seen", 32'(done), 32'd1);
    chk("end_q", 32'(q), d ? 32'd0 : 32'(ld));
  endtask

  initial begin
    int n;
    clr_n = 1'b0; start = 0; abort = 0; en = 0; dir = 0; load_val = '0;
    model_reset();
    @(negedge clk);
    check_all();
    clr_n = 1'b1;
    step(0, 0, 0, 0, 0);

    // Reset mid-run: asynchronous clear with no done pulse afterward.
    step(1, 0, 1, 0, 31);
    for (int i = 0; i < 10; i++) step(0, 0, 1, 0, 31);
    chk("pre_reset_q", 32'(q), 32'd10);
    #2 clr_n = 1'b0;
    #1;
    model_reset();
    chk("arst_q", 32'(q), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_last", 32'(last), 32'd0);
    @(negedge clk);
    check_all();
    clr_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);

    // Up count 0..31.
    run_seq(31, 0, 0, n);
    chk("up31_en_cycles", 32'(n), 32'd32);
    step(0, 0, 1, 0, 0);
    chk("up31_hold_q", 32'(q), 32'd31);

    // Down count with stalls.
    run_seq(5, 1, 1, n);
    chk("down5_en_cycles", 32'(n), 32'd6);

    // Edge values.
    run_seq(0, 0, 0, n);
    chk("zero_en_cycles", 32'(n), 32'd1);
    run_seq(0, 1, 0, n);
    chk("zero_down_en_cycles", 32'(n), 32'd1);
    run_seq(MAXV, 0, 0, n);
    chk("full_en_cycles", 32'(n), 32'(MAXV + 1));
    run_seq(MAXV, 1, 0, n);
    chk("full_down_en_cycles", 32'(n), 32'(MAXV + 1));

    // Abort with an ignored start at q = 7.
    step(0, 0, 0, 0, 0);
    step(1, 0, 1, 0, 20);
    for (int i = 0; i < 7; i++) step(0, 0, 1, 0, 20);
    chk("abort_pre_q", 32'(q), 32'd7);
    step(1, 1, 1, 1, 50);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_q", 32'(q), 32'd7);
    chk("abort_done", 32'(done), 32'd0);
    step(0, 0, 1, 0, 0);
    chk("abort_no_done", 32'(done), 32'd0);
    step(1, 1, 1, 0, 9);
    chk("idle_start_abort_busy", 32'(busy), 32'd0);

    // Back-to-back: second start lands during the done cycle.
    run_seq(10, 0, 0, n);
    run_seq(3, 0, 0, n);
    chk("b2b_en_cycles", 32'(n), 32'd4);

    // Randomized run.
    for (int i = 0; i < 3000; i++) begin
      bit st, ab, e, d;
      int ld;
      st = ($urandom_range(0, 3) == 0);
      ab = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 3) != 0);
      d  = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       ld = 0;
        1:       ld = MAXV;
        default: ld = $urandom_range(0, 12);
      endcase
      step(st, ab, e, d, ld);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
